// File: rtl/fb_port_arbiter.sv
// Two-client read-port arbiter for the frame-buffer RAM: VGA scan-out has priority,
// the serial dump reader is guaranteed a grant after STARVE_MAX denied cycles.
module fb_port_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_BITS    = 22,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vga_req,
  input  logic [ADDR_BITS-1:0]  vga_addr,
  output logic                  vga_gnt,
  output logic                  vga_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_miss,
  input  logic                  ser_req,
  input  logic [ADDR_BITS-1:0]  ser_addr,
  output logic                  ser_gnt,
  output logic                  ser_rvalid,
  output logic [DATA_WIDTH-1:0] ser_rdata,
  output logic                  ram_re,
  output logic [ADDR_BITS-1:0]  ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VGA,
    ST_SER
  } owner_t;

  owner_t                  state;
  logic [CNT_W-1:0]        starve_cnt;
  logic                    forced;
  logic                    any_gnt;
  logic                    ram_owner;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_owner;
  logic [DATA_WIDTH-1:0]   vga_hold;
  logic [DATA_WIDTH-1:0]   ser_hold;

  // Grants are combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    forced   = ser_req && (starve_cnt == STARVE_LIMIT);
    ser_gnt  = rst && ser_req && (forced || !vga_req);
    vga_gnt  = rst && vga_req && !forced;
    vga_miss = rst && vga_req && forced;
    any_gnt  = vga_gnt || ser_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!ser_req || ser_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_owner <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      ram_re <= any_gnt;
      if (ser_gnt) begin
        ram_addr  <= ser_addr;
        ram_owner <= 1'b1;
        state     <= ST_SER;
      end else if (vga_gnt) begin
        ram_addr  <= vga_addr;
        ram_owner <= 1'b0;
        state     <= ST_VGA;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Tag pipe tracks the owner of each issued read until its RAM data arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      for (int k = READ_LATENCY - 1; k > 0; k--) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_owner[k] <= tag_owner[k-1];
      end
      tag_valid[0] <= ram_re;
      tag_owner[0] <= ram_owner;
    end
  end

  always_comb begin
    vga_rvalid = tag_valid[READ_LATENCY-1] && !tag_owner[READ_LATENCY-1];
    ser_rvalid = tag_valid[READ_LATENCY-1] &&  tag_owner[READ_LATENCY-1];
    vga_rdata  = vga_rvalid ? ram_rdata : vga_hold;
    ser_rdata  = ser_rvalid ? ram_rdata : ser_hold;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_hold <= '0;
      ser_hold <= '0;
    end else begin
      if (vga_rvalid) vga_hold <= ram_rdata;
      if (ser_rvalid) ser_hold <= ram_rdata;
    end
  end

  // The debug owner state must always agree with the issued read enable.
  a_state_matches_re: assert property (@(posedge clk) disable iff (!rst)
    (state == ST_IDLE) == !ram_re);

  a_single_grant: assert property (@(posedge clk) disable iff (!rst)
    !(vga_gnt && ser_gnt));

endmodule
